// File: rtl/match_len_tracker.sv
// Match-length tracker: counts string then pattern characters, latches the final
// lengths for a downstream matcher and hands them off with a rdy/ack handshake.
module match_len_tracker #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int WRAP    = 1,
    localparam int SW = $clog2(STR_MAX + 1),
    localparam int PW = $clog2(PAT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrlsig,
    input  logic          pcnt_clr,
    input  logic          str_valid,
    input  logic          str_last,
    input  logic          pat_valid,
    input  logic          pat_last,
    input  logic          ack,
    output logic [SW-1:0] scnt,
    output logic [PW-1:0] plen,
    output logic [SW-1:0] slen_q,
    output logic [PW-1:0] plen_q,
    output logic          rdy,
    output logic          str_ovf,
    output logic          pat_ovf,
    output logic [1:0]    state
);

    // state  | meaning
    // IDLE   | waiting for the first string character
    // S_STR  | counting string characters
    // S_PAT  | counting pattern characters
    // S_RDY  | lengths latched, waiting for ack
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] S_STR = 2'd1;
    localparam logic [1:0] S_PAT = 2'd2;
    localparam logic [1:0] S_RDY = 2'd3;

    localparam logic [SW-1:0] STR_TOP = SW'(STR_MAX);
    localparam logic [PW-1:0] PAT_TOP = PW'(PAT_MAX);

    logic [1:0]    st_q, st_d;
    logic [SW-1:0] str_cnt_q, str_cnt_d;
    logic [PW-1:0] pat_cnt_q, pat_cnt_d;
    logic [SW-1:0] slen_lat_q, slen_lat_d;
    logic [PW-1:0] plen_lat_q, plen_lat_d;
    logic          str_ovf_q, str_ovf_d;
    logic          pat_ovf_q, pat_ovf_d;

    logic [SW-1:0] str_inc;
    logic [PW-1:0] pat_inc;
    logic          str_top_hit;
    logic          pat_top_hit;

    // Incrementing from MAX either wraps to 0 or sticks at MAX.
    always_comb begin
        str_top_hit = (str_cnt_q == STR_TOP);
        pat_top_hit = (pat_cnt_q == PAT_TOP);
        str_inc     = str_cnt_q + SW'(1);
        pat_inc     = pat_cnt_q + PW'(1);
        if (str_top_hit) begin
            str_inc = (WRAP != 0) ? '0 : STR_TOP;
        end
        if (pat_top_hit) begin
            pat_inc = (WRAP != 0) ? '0 : PAT_TOP;
        end
    end

    always_comb begin
        st_d       = st_q;
        str_cnt_d  = str_cnt_q;
        pat_cnt_d  = pat_cnt_q;
        slen_lat_d = slen_lat_q;
        plen_lat_d = plen_lat_q;
        str_ovf_d  = str_ovf_q;
        pat_ovf_d  = pat_ovf_q;
        case (st_q)
            IDLE: begin
                if (str_valid) begin
                    str_cnt_d = SW'(1);
                    if (str_last) begin
                        slen_lat_d = SW'(1);
                        st_d       = S_PAT;
                    end else begin
                        st_d = S_STR;
                    end
                end
            end
            S_STR: begin
                if (str_valid) begin
                    str_cnt_d = str_inc;
                    if (str_top_hit) begin
                        str_ovf_d = 1'b1;
                    end
                    if (str_last) begin
                        slen_lat_d = str_inc;
                        st_d       = S_PAT;
                    end
                end
            end
            S_PAT: begin
                // A clear or disabled count swallows any same-cycle character.
                if (pcnt_clr || !ctrlsig) begin
                    pat_cnt_d = '0;
                    if (pcnt_clr) begin
                        pat_ovf_d = 1'b0;
                    end
                end else if (pat_valid) begin
                    pat_cnt_d = pat_inc;
                    if (pat_top_hit) begin
                        pat_ovf_d = 1'b1;
                    end
                    if (pat_last) begin
                        plen_lat_d = pat_inc;
                        st_d       = S_RDY;
                    end
                end
            end
            S_RDY: begin
                if (ack) begin
                    st_d      = IDLE;
                    str_cnt_d = '0;
                    pat_cnt_d = '0;
                    str_ovf_d = 1'b0;
                    pat_ovf_d = 1'b0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= IDLE;
            str_cnt_q  <= '0;
            pat_cnt_q  <= '0;
            slen_lat_q <= '0;
            plen_lat_q <= '0;
            str_ovf_q  <= 1'b0;
            pat_ovf_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            str_cnt_q  <= str_cnt_d;
            pat_cnt_q  <= pat_cnt_d;
            slen_lat_q <= slen_lat_d;
            plen_lat_q <= plen_lat_d;
            str_ovf_q  <= str_ovf_d;
            pat_ovf_q  <= pat_ovf_d;
        end
    end

    assign state   = st_q;
    assign scnt    = str_cnt_q;
    assign plen    = pat_cnt_q;
    assign slen_q  = slen_lat_q;
    assign plen_q  = plen_lat_q;
    assign rdy     = (st_q == S_RDY);
    assign str_ovf = str_ovf_q;
    assign pat_ovf = pat_ovf_q;

endmodule

// File: tb/tb_match_len_tracker.sv
// Scenario bench for match_len_tracker: a wrapping instance (A) and a saturating
// instance (B) share stimulus; expected snapshots are queued, then popped and compared.
module tb_match_len_tracker;

    logic clk = 1'b0;
    logic rst, ctrlsig, pcnt_clr, str_valid, str_last, pat_valid, pat_last, ack;

    logic [5:0] scnt_a, slen_a, scnt_b, slen_b;
    logic [3:0] plen_a, plenq_a, plen_b, plenq_b;
    logic       rdy_a, sovf_a, povf_a, rdy_b, sovf_b, povf_b;
    logic [1:0] state_a, state_b;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    match_len_tracker #(.STR_MAX(32), .PAT_MAX(8), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst), .ctrlsig(ctrlsig), .pcnt_clr(pcnt_clr),
        .str_valid(str_valid), .str_last(str_last), .pat_valid(pat_valid),
        .pat_last(pat_last), .ack(ack), .scnt(scnt_a), .plen(plen_a),
        .slen_q(slen_a), .plen_q(plenq_a), .rdy(rdy_a), .str_ovf(sovf_a),
        .pat_ovf(povf_a), .state(state_a)
    );

    match_len_tracker #(.STR_MAX(32), .PAT_MAX(8), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst), .ctrlsig(ctrlsig), .pcnt_clr(pcnt_clr),
        .str_valid(str_valid), .str_last(str_last), .pat_valid(pat_valid),
        .pat_last(pat_last), .ack(ack), .scnt(scnt_b), .plen(plen_b),
        .slen_q(slen_b), .plen_q(plenq_b), .rdy(rdy_b), .str_ovf(sovf_b),
        .pat_ovf(povf_b), .state(state_b)
    );

    // Snapshot: {state, scnt, plen, slen_q, plen_q, rdy, str_ovf, pat_ovf}
    function automatic logic [24:0] pk(input int st, sc, pl, sl, pq, rd, so, po);
        return {st[1:0], sc[5:0], pl[3:0], sl[5:0], pq[3:0], rd[0], so[0], po[0]};
    endfunction

    function automatic logic [24:0] obs_a();
        return {state_a, scnt_a, plen_a, slen_a, plenq_a, rdy_a, sovf_a, povf_a};
    endfunction

    function automatic logic [24:0] obs_b();
        return {state_b, scnt_b, plen_b, slen_b, plenq_b, rdy_b, sovf_b, povf_b};
    endfunction

    task automatic drive(input logic sv, sl, pv, pl, ac, cs, pc, r);
        str_valid = sv; str_last = sl; pat_valid = pv; pat_last = pl;
        ack = ac; ctrlsig = cs; pcnt_clr = pc; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic str_ch(input logic last);
        drive(1'b1, last, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pat_ch(input logic last);
        drive(1'b0, 1'b0, 1'b1, last, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        exp_t e;
        sb.push_back('{tag: "reset_a", v: pk(0, 0, 0, 0, 0, 0, 0, 0)});
        sb.push_back('{tag: "reset_b", v: pk(0, 0, 0, 0, 0, 0, 0, 0)});
        do_reset();
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_b(), e.v); end
    endtask

    task automatic test_normal_pass();
        exp_t e;
        do_reset();
        sb.push_back('{tag: "s1_first_char", v: pk(1, 1, 0, 0, 0, 0, 0, 0)});
        str_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_str4", v: pk(1, 4, 0, 0, 0, 0, 0, 0)});
        for (int i = 0; i < 3; i++) str_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_str_last", v: pk(2, 5, 0, 5, 0, 0, 0, 0)});
        str_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_pat2", v: pk(2, 5, 2, 5, 0, 0, 0, 0)});
        pat_ch(1'b0);
        pat_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_ack_in_pat", v: pk(2, 5, 2, 5, 0, 0, 0, 0)});
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_pat_last", v: pk(3, 5, 3, 5, 3, 1, 0, 0)});
        pat_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_rdy_hold", v: pk(3, 5, 3, 5, 3, 1, 0, 0)});
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_ack", v: pk(0, 0, 0, 5, 3, 0, 0, 0)});
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s1_back_to_back", v: pk(2, 1, 0, 1, 3, 0, 0, 0)});
        str_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        sb.push_back('{tag: "s2_str32", v: pk(1, 32, 0, 0, 0, 0, 0, 0)});
        for (int i = 0; i < 32; i++) str_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s2_str_wrap", v: pk(1, 0, 0, 0, 0, 0, 1, 0)});
        str_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s2_str_last", v: pk(2, 2, 0, 2, 0, 0, 1, 0)});
        str_ch(1'b0);
        str_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s2_str_in_pat", v: pk(2, 2, 0, 2, 0, 0, 1, 0)});
        str_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
    endtask

    task automatic test_saturate();
        exp_t e;
        do_reset();
        str_ch(1'b1);
        sb.push_back('{tag: "s3_pat8_b", v: pk(2, 1, 8, 1, 0, 0, 0, 0)});
        for (int i = 0; i < 8; i++) pat_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_b(), e.v); end
        sb.push_back('{tag: "s3_pat_sat_b", v: pk(2, 1, 8, 1, 0, 0, 0, 1)});
        pat_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_b(), e.v); end
        sb.push_back('{tag: "s3_pat_last_b", v: pk(3, 1, 8, 1, 8, 1, 0, 1)});
        sb.push_back('{tag: "s3_pat_last_a", v: pk(3, 1, 1, 1, 1, 1, 0, 1)});
        pat_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_b(), e.v); end
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s3_ack_b", v: pk(0, 0, 0, 1, 8, 0, 0, 0)});
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_b() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_b(), e.v); end
    endtask

    task automatic test_clear();
        exp_t e;
        do_reset();
        str_ch(1'b1);
        for (int i = 0; i < 9; i++) pat_ch(1'b0);
        sb.push_back('{tag: "s4_pat4_ovf", v: pk(2, 1, 4, 1, 0, 0, 0, 1)});
        for (int i = 0; i < 4; i++) pat_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s4_clear", v: pk(2, 1, 0, 1, 0, 0, 0, 0)});
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s4_pat_last", v: pk(3, 1, 2, 1, 2, 1, 0, 0)});
        pat_ch(1'b0);
        pat_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
    endtask

    task automatic test_ctrlsig();
        exp_t e;
        do_reset();
        str_ch(1'b1);
        sb.push_back('{tag: "s5_pat1", v: pk(2, 1, 1, 1, 0, 0, 0, 0)});
        pat_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{tag: "s5_ctrl_low", v: pk(2, 1, 0, 1, 0, 0, 0, 0)});
            drive(1'b0, 1'b0, 1'b1, (i == 2), 1'b0, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front(); checks++;
            if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        end
        sb.push_back('{tag: "s5_pat_last", v: pk(3, 1, 1, 1, 1, 1, 0, 0)});
        pat_ch(1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        sb.push_back('{tag: "s6_str7", v: pk(1, 7, 0, 0, 0, 0, 0, 0)});
        for (int i = 0; i < 7; i++) str_ch(1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s6_rst_override", v: pk(0, 0, 0, 0, 0, 0, 0, 0)});
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
        sb.push_back('{tag: "s6_stray_idle", v: pk(0, 0, 0, 0, 0, 0, 0, 0)});
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (obs_a() !== e.v) begin errors++; $display("FAIL %s got %h expected %h", e.tag, obs_a(), e.v); end
    endtask

    initial begin
        rst = 1'b1; ctrlsig = 1'b1; pcnt_clr = 1'b0; str_valid = 1'b0;
        str_last = 1'b0; pat_valid = 1'b0; pat_last = 1'b0; ack = 1'b0;
        test_reset();
        test_normal_pass();
        test_wrap();
        test_saturate();
        test_clear();
        test_ctrlsig();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
